hazard_fwd_ctrl: RTL
====================

# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage processor. It tracks the destination tags of in-flight instructions in EX, MEM and WB, and drives the 2-bit select lines of the operand `mux_4` instances in EX. It also detects load-use hazards (1-cycle stall) and taken-branch flushes. It sits beside the ID/EX pipeline register and is the sole owner of operand-mux selection.

## Interface
- REG_ADDR_W, 3, register index width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- id_rd  in  REG_ADDR_W  ID destination register
- id_wr_en  in  1  ID instruction writes register file
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 0=regfile, 1=EX/MEM ALU result, 2=MEM/WB result, 3=WB writeback value
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX contents

## Operation
- Internal tag stages EX, MEM, WB; each tag is {valid, rd, wr_en, is_load}.
- Each clock: WB<=MEM, MEM<=EX. EX<=bubble (valid=0) if stall or flush, else the ID tag with valid=id_valid.
- Operand A select is computed per ID instruction and registered into the ID/EX datapath by the pipeline:
  - 1 if EX tag valid, wr_en, !is_load, and rd==id_rs1.
  - Else 2 if MEM tag valid, wr_en, and rd==id_rs1.
  - Else 3 if WB tag valid, wr_en, and rd==id_rs1.
  - Else 0.
- Operand B select uses the same rule with id_rs2. When id_use_rsN=0 or id_valid=0, the select is 0.
- Priority is youngest producer first: EX > MEM > WB.
- Load-use hazard: stall=1 when id_valid, the EX tag is a valid load with wr_en, and its rd matches a used source (rs1 with use_rs1, or rs2 with use_rs2).
- After the 1-cycle bubble, the load is in MEM, so the same instruction gets sel=2.
- flush=ex_branch_taken.
- Flush overrides stall. With flush=1, stall is forced to 0, EX receives a bubble, and the ID instruction is discarded.
- Register 0 has no special treatment; it is forwarded like any other register.

## Timing
- fwd_*_sel, stall and flush are combinational from the registered tags plus the current ID inputs, with no added latency.
- Tags update on the rising edge of clk only.
- During stall, MEM and WB still advance and EX takes a bubble.
- Reset, asynchronous at any time, clears all tag valids. While reset is high and on the first cycle after it, fwd_a_sel=fwd_b_sel=0, stall=0, and flush=ex_branch_taken. Reset mid-stall abandons the stall; no stale forwarding remains.
- Worst-case stall length is 1 cycle per load-use pair. Back-to-back dependent loads each stall once.

## Configuration
- HAZ_PERF_CNT_EN defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each counts cycles with stall=1 (respectively flush=1).
  - Both saturate at 16'hFFFF and reset to 0 on reset.
- HAZ_PERF_CNT_EN not defined: neither port nor the counters exist. Functional behaviour is otherwise identical.

## Test plan
- Back-to-back ALU dependence: `add r1` then next-cycle ID reads r1 as rs1 -> fwd_a_sel=1, stall=0.
- Distance sweep: producer r2 with consumer 2, 3 and 4 cycles later (rs2) -> fwd_b_sel=2, 3, 0 respectively.
- Load-use: `lw r3` followed by use of r3 on rs1 -> stall=1 for exactly 1 cycle. The next cycle has stall=0 and fwd_a_sel=2. EX tag is a bubble for that cycle.
- Priority: EX and MEM both write r4 and the consumer reads r4 on both operands -> fwd_a_sel=fwd_b_sel=1. With id_use_rs2=0 -> fwd_b_sel=0.
- Flush vs stall: load-use condition present with ex_branch_taken=1 -> flush=1, stall=0, and the EX tag is invalid on the next cycle.
- Reset mid-operation: assert reset during a stall with MEM/WB tags valid -> immediately stall=0 and selects=0. With HAZ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: tracks EX/MEM/WB destination tags, drives operand mux selects,
// detects load-use stalls and taken-branch flushes. Optional HAZ_PERF_CNT_EN adds stall/flush counters.
module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr_en,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  flush
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    localparam int STAGES  = 3;  // index 0=EX, 1=MEM, 2=WB
    localparam int NUM_OPS = 2;  // operand A, operand B

    logic [STAGES-1:0]                 vld_pipe;
    logic [STAGES-1:0]                 wr_pipe;
    logic [STAGES-1:0][REG_ADDR_W-1:0] rd_pipe;
    logic                              ex_load;

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_rs;
    logic [NUM_OPS-1:0]                 op_use;
    logic [NUM_OPS-1:0][1:0]            op_sel;
    logic [NUM_OPS-1:0]                 op_luse;

    assign op_rs  = {id_rs2, id_rs1};
    assign op_use = {id_use_rs2, id_use_rs1};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        logic [STAGES-1:0] hit;
        logic [1:0]        sel;
        logic              active;

        for (genvar s = 0; s < STAGES; s++) begin : g_stg
            assign hit[s] = vld_pipe[s] & wr_pipe[s] & (rd_pipe[s] == op_rs[i]);
        end

        assign active = id_valid & op_use[i];

        // A load in EX has no result yet, so it falls through to older producers.
        always_comb begin
            sel = 2'd0;
            if (active) begin
                if (hit[0] && !ex_load) sel = 2'd1;
                else if (hit[1])        sel = 2'd2;
                else if (hit[2])        sel = 2'd3;
            end
        end

        assign op_sel[i]  = sel;
        assign op_luse[i] = active & hit[0] & ex_load;
    end

    assign fwd_a_sel = op_sel[0];
    assign fwd_b_sel = op_sel[1];
    assign flush     = ex_branch_taken;
    assign stall     = (|op_luse) & ~ex_branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            wr_pipe  <= '0;
            rd_pipe  <= '0;
            ex_load  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], id_valid & ~stall & ~flush};
            wr_pipe  <= {wr_pipe[STAGES-2:0], id_wr_en};
            rd_pipe  <= {rd_pipe[STAGES-2:0], id_rd};
            ex_load  <= id_is_load;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
